// File: rtl/nav_drive_scheduler_pkg.sv
// Shared encodings and tuning constants for the navigation drive scheduler.
// MC word layout: bit 4 = direction (1 forward), bits 3:0 = speed magnitude.
package nav_drive_scheduler_pkg;

    localparam int MC_W   = 5;
    localparam int MAG_W  = 4;
    localparam int DIST_W = 8;
    localparam int MC_DIR = 4;

    localparam logic [MC_W-1:0] MC_ZERO = 5'h10;

    localparam logic [2:0] ST_MANUAL = 3'd0;
    localparam logic [2:0] ST_CRUISE = 3'd1;
    localparam logic [2:0] ST_BRAKE  = 3'd2;
    localparam logic [2:0] ST_TURN   = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    localparam logic [DIST_W-1:0] STOP_DIST  = 8'd20;
    localparam logic [DIST_W-1:0] CLEAR_DIST = 8'd30;
    localparam logic [DIST_W-1:0] TURN_TICKS = 8'd40;
    localparam logic [DIST_W-1:0] WD_TICKS   = 8'd100;
    localparam logic [MAG_W-1:0]  CRUISE_SPD = 4'd10;
    localparam logic [MAG_W-1:0]  TURN_SPD   = 4'd6;
    localparam logic [MAG_W-1:0]  RAMP_STEP  = 4'd1;

    typedef logic [MC_W-1:0] mc_word_t;

    function automatic logic [MAG_W-1:0] step_limit(input logic [MAG_W-1:0] diff);
        return (diff < RAMP_STEP) ? diff : RAMP_STEP;
    endfunction

endpackage

// File: rtl/nav_drive_scheduler_mc_ramp.sv
// Slew-rate limiter for one motor command word; moves at most RAMP_STEP per TICK
// and passes through magnitude zero before reversing direction.
module mc_ramp
    import nav_drive_scheduler_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            tick_i,
    input  logic [MC_W-1:0] target_i,
    output logic [MC_W-1:0] mc_o
);

    mc_word_t         mc_q;
    mc_word_t         mc_d;
    logic [MAG_W-1:0] cur_mag_s;
    logic [MAG_W-1:0] tgt_mag_s;

    assign cur_mag_s = mc_q[MAG_W-1:0];
    assign tgt_mag_s = target_i[MAG_W-1:0];

    // Next ramp value: decelerate to zero on a reversal, otherwise approach target
    always_comb begin
        mc_d = mc_q;
        if (tick_i) begin
            if (mc_q[MC_DIR] != target_i[MC_DIR]) begin
                if (cur_mag_s != 4'd0) begin
                    mc_d[MAG_W-1:0] = cur_mag_s - step_limit(cur_mag_s);
                end else begin
                    mc_d[MC_DIR] = target_i[MC_DIR];
                end
            end else if (cur_mag_s < tgt_mag_s) begin
                mc_d[MAG_W-1:0] = cur_mag_s + step_limit(tgt_mag_s - cur_mag_s);
            end else if (cur_mag_s > tgt_mag_s) begin
                mc_d[MAG_W-1:0] = cur_mag_s - step_limit(cur_mag_s - tgt_mag_s);
            end else begin
                mc_d = mc_q;
            end
        end else begin
            mc_d = mc_q;
        end
    end

    // Command register; reset snaps straight to stop without ramping
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            mc_q <= MC_ZERO;
        end else begin
            mc_q <= mc_d;
        end
    end

    assign mc_o = mc_q;

endmodule

// File: rtl/nav_drive_scheduler.sv
// Selects manual or autonomous obstacle-avoidance motor targets and feeds them
// through per-motor slew limiters toward the PWM block.
module nav_drive_scheduler
    import nav_drive_scheduler_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              tick_i,
    input  logic              auto_en_i,
    input  logic [MC_W-1:0]   man_mc1_i,
    input  logic [MC_W-1:0]   man_mc2_i,
    input  logic [DIST_W-1:0] dist1_i,
    input  logic [DIST_W-1:0] dist2_i,
    input  logic              dist_valid_i,
    output logic [MC_W-1:0]   mc1_o,
    output logic [MC_W-1:0]   mc2_o,
    output logic [2:0]        state_o,
    output logic              obst_o
);

    logic [2:0]        state_q, state_d;
    logic [DIST_W-1:0] d1_q, d1_d, d2_q, d2_d;
    logic [DIST_W-1:0] turn_tmr_q, turn_tmr_d;
    logic [DIST_W-1:0] wd_q, wd_d;
    logic              turn_right_q, turn_right_d;
    logic              obst_q, obst_d;
    logic [DIST_W-1:0] min_s;
    logic              wd_expired_s;
    mc_word_t          tgt1_s, tgt2_s, mc1_s, mc2_s;

    // Fresh readings take effect in the cycle they arrive
    always_comb begin
        d1_d  = dist_valid_i ? dist1_i : d1_q;
        d2_d  = dist_valid_i ? dist2_i : d2_q;
        min_s = (d1_d < d2_d) ? d1_d : d2_d;
    end

    // Motor targets follow the registered state, so a TICK coinciding with a
    // state change still ramps toward the old target
    always_comb begin
        case (state_q)
            ST_MANUAL: begin
                tgt1_s = man_mc1_i;
                tgt2_s = man_mc2_i;
            end
            ST_CRUISE: begin
                tgt1_s = {1'b1, CRUISE_SPD};
                tgt2_s = {1'b1, CRUISE_SPD};
            end
            ST_TURN: begin
                tgt1_s = {turn_right_q, TURN_SPD};
                tgt2_s = {~turn_right_q, TURN_SPD};
            end
            default: begin
                tgt1_s = MC_ZERO;
                tgt2_s = MC_ZERO;
            end
        endcase
    end

    // Watchdog: TICKs since the last reading, idle in manual mode, saturating
    always_comb begin
        if (dist_valid_i || (state_q == ST_MANUAL)) begin
            wd_d = 8'd0;
        end else if (tick_i && (wd_q < WD_TICKS)) begin
            wd_d = wd_q + 8'd1;
        end else begin
            wd_d = wd_q;
        end
        wd_expired_s = (wd_q == WD_TICKS) && !dist_valid_i;
    end

    // Mode FSM with turn-slice timer and turn-direction latch
    always_comb begin
        state_d      = state_q;
        turn_tmr_d   = turn_tmr_q;
        turn_right_d = turn_right_q;
        if (!auto_en_i) begin
            state_d = ST_MANUAL;
        end else if (wd_expired_s) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_MANUAL: state_d = ST_CRUISE;
                ST_CRUISE: begin
                    if (dist_valid_i && (min_s < STOP_DIST)) begin
                        state_d = ST_BRAKE;
                    end else begin
                        state_d = ST_CRUISE;
                    end
                end
                ST_BRAKE: begin
                    if ((mc1_s[MAG_W-1:0] == 4'd0) && (mc2_s[MAG_W-1:0] == 4'd0)) begin
                        state_d      = ST_TURN;
                        turn_right_d = (d1_d <= d2_d);
                        turn_tmr_d   = TURN_TICKS;
                    end else begin
                        state_d = ST_BRAKE;
                    end
                end
                ST_TURN: begin
                    if (turn_tmr_q == 8'd0) begin
                        if (min_s >= CLEAR_DIST) begin
                            state_d = ST_CRUISE;
                        end else begin
                            turn_tmr_d = TURN_TICKS;
                        end
                    end else if (tick_i) begin
                        turn_tmr_d = turn_tmr_q - 8'd1;
                    end else begin
                        turn_tmr_d = turn_tmr_q;
                    end
                end
                ST_FAULT: begin
                    if (dist_valid_i) begin
                        state_d = ST_BRAKE;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                default: state_d = ST_MANUAL;
            endcase
        end
        obst_d = (state_d == ST_BRAKE) || (state_d == ST_TURN) || (state_d == ST_FAULT);
    end

    // State, timers and captured distances
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_MANUAL;
            d1_q         <= 8'd0;
            d2_q         <= 8'd0;
            turn_tmr_q   <= 8'd0;
            wd_q         <= 8'd0;
            turn_right_q <= 1'b1;
            obst_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            d1_q         <= d1_d;
            d2_q         <= d2_d;
            turn_tmr_q   <= turn_tmr_d;
            wd_q         <= wd_d;
            turn_right_q <= turn_right_d;
            obst_q       <= obst_d;
        end
    end

    mc_ramp u_ramp1 (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .tick_i    (tick_i),
        .target_i  (tgt1_s),
        .mc_o      (mc1_s)
    );

    mc_ramp u_ramp2 (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .tick_i    (tick_i),
        .target_i  (tgt2_s),
        .mc_o      (mc2_s)
    );

    assign mc1_o   = mc1_s;
    assign mc2_o   = mc2_s;
    assign state_o = state_q;
    assign obst_o  = obst_q;

endmodule

// File: tb/tb_nav_drive_scheduler.sv
// Bench for nav_drive_scheduler: directed scenarios plus random traffic, all
// checked each cycle against a behavioural model of the drive scheduler.
module tb_nav_drive_scheduler;

    localparam int MANUAL = 0, CRUISE = 1, BRAKE = 2, TURN = 3, FAULT = 4;
    localparam int STOP = 20, CLEAR = 30, CSPD = 10, TSPD = 6, TTICKS = 40, WDT = 100, STEP = 1;

    logic       clk = 1'b0;
    logic       reset_n_i, tick_i, auto_en_i, dist_valid_i;
    logic [4:0] man_mc1_i, man_mc2_i;
    logic [7:0] dist1_i, dist2_i;
    logic [4:0] mc1_o, mc2_o;
    logic [2:0] state_o;
    logic       obst_o;

    always #5 clk = ~clk;

    nav_drive_scheduler dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n_i),
        .tick_i       (tick_i),
        .auto_en_i    (auto_en_i),
        .man_mc1_i    (man_mc1_i),
        .man_mc2_i    (man_mc2_i),
        .dist1_i      (dist1_i),
        .dist2_i      (dist2_i),
        .dist_valid_i (dist_valid_i),
        .mc1_o        (mc1_o),
        .mc2_o        (mc2_o),
        .state_o      (state_o),
        .obst_o       (obst_o)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: motor as (direction, magnitude), mode as a small integer
    int m_state, m_d1, m_d2, m_right, m_tmr, m_wd;
    int m_dir [2];
    int m_mag [2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_state = MANUAL; m_d1 = 0; m_d2 = 0; m_right = 1; m_tmr = 0; m_wd = 0;
        for (int k = 0; k < 2; k++) begin
            m_dir[k] = 1;
            m_mag[k] = 0;
        end
    endtask

    // One clock: compute the model's successor, clock the DUT, compare everything
    task automatic step(input logic tk);
        int ns, nd1, nd2, nr, nt, nw, mn, tdir, tmag;
        int ndir [2];
        int nmag [2];
        int tgt [2];
        tick_i = tk;
        if (!reset_n_i) begin
            @(posedge clk); #1;
            model_reset();
        end else begin
            nd1 = dist_valid_i ? int'(dist1_i) : m_d1;
            nd2 = dist_valid_i ? int'(dist2_i) : m_d2;
            mn  = imin(nd1, nd2);
            case (m_state)
                MANUAL:  begin tgt[0] = man_mc1_i; tgt[1] = man_mc2_i; end
                CRUISE:  begin tgt[0] = 16 + CSPD; tgt[1] = 16 + CSPD; end
                TURN:    begin tgt[0] = m_right * 16 + TSPD; tgt[1] = (1 - m_right) * 16 + TSPD; end
                default: begin tgt[0] = 16; tgt[1] = 16; end
            endcase
            for (int k = 0; k < 2; k++) begin
                ndir[k] = m_dir[k];
                nmag[k] = m_mag[k];
                tdir = tgt[k] / 16;
                tmag = tgt[k] % 16;
                if (tk) begin
                    if (m_dir[k] != tdir) begin
                        if (m_mag[k] > 0) nmag[k] = m_mag[k] - imin(STEP, m_mag[k]);
                        else ndir[k] = tdir;
                    end else if (m_mag[k] < tmag) begin
                        nmag[k] = m_mag[k] + imin(STEP, tmag - m_mag[k]);
                    end else begin
                        nmag[k] = m_mag[k] - imin(STEP, m_mag[k] - tmag);
                    end
                end
            end
            if (dist_valid_i || m_state == MANUAL) nw = 0;
            else if (tk && m_wd < WDT) nw = m_wd + 1;
            else nw = m_wd;
            ns = m_state; nr = m_right; nt = m_tmr;
            if (!auto_en_i) ns = MANUAL;
            else if (m_wd == WDT && !dist_valid_i) ns = FAULT;
            else if (m_state == MANUAL) ns = CRUISE;
            else if (m_state == CRUISE) begin
                if (dist_valid_i && mn < STOP) ns = BRAKE;
            end else if (m_state == BRAKE) begin
                if (m_mag[0] == 0 && m_mag[1] == 0) begin
                    ns = TURN; nr = (nd1 <= nd2) ? 1 : 0; nt = TTICKS;
                end
            end else if (m_state == TURN) begin
                if (m_tmr == 0) begin
                    if (mn >= CLEAR) ns = CRUISE;
                    else nt = TTICKS;
                end else if (tk) nt = m_tmr - 1;
            end else if (m_state == FAULT) begin
                if (dist_valid_i) ns = BRAKE;
            end
            @(posedge clk); #1;
            m_state = ns; m_d1 = nd1; m_d2 = nd2; m_right = nr; m_tmr = nt; m_wd = nw;
            for (int k = 0; k < 2; k++) begin
                m_dir[k] = ndir[k];
                m_mag[k] = nmag[k];
            end
        end
        check("mc1", int'(mc1_o), m_dir[0] * 16 + m_mag[0]);
        check("mc2", int'(mc2_o), m_dir[1] * 16 + m_mag[1]);
        check("state", int'(state_o), m_state);
        check("obst", int'(obst_o), (m_state == BRAKE || m_state == TURN || m_state == FAULT) ? 1 : 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0); step(1'b0); step(1'b0); step(1'b1);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic pulse_dv(input int a, input int b);
        dist1_i = 8'(a);
        dist2_i = 8'(b);
        dist_valid_i = 1'b1;
        step(1'b0);
        dist_valid_i = 1'b0;
    endtask

    initial begin
        reset_n_i = 1'b0; tick_i = 1'b0; auto_en_i = 1'b0; dist_valid_i = 1'b0;
        man_mc1_i = 5'h10; man_mc2_i = 5'h10; dist1_i = 8'd0; dist2_i = 8'd0;
        model_reset();
        run(2);
        check("reset_mc1", int'(mc1_o), 32'h10);
        check("reset_state", int'(state_o), MANUAL);
        reset_n_i = 1'b1;

        // Manual ramp up, then a reversal through zero
        man_mc1_i = 5'h1F;
        ticks(14);
        check("up14", int'(mc1_o), 32'h1E);
        ticks(1);
        check("up15", int'(mc1_o), 32'h1F);
        man_mc1_i = 5'h18;
        ticks(7);
        check("down_to_18", int'(mc1_o), 32'h18);
        man_mc1_i = 5'h04;
        ticks(8);
        check("rev8", int'(mc1_o), 32'h10);
        ticks(1);
        check("rev9_flip", int'(mc1_o), 32'h00);
        ticks(4);
        check("rev13", int'(mc1_o), 32'h04);

        // Autonomous cruise, brake, right turn
        auto_en_i = 1'b1;
        pulse_dv(50, 50);
        ticks(16);
        check("cruise_mc1", int'(mc1_o), 32'h1A);
        check("cruise_mc2", int'(mc2_o), 32'h1A);
        pulse_dv(15, 60);
        check("brake_state", int'(state_o), BRAKE);
        check("brake_obst", int'(obst_o), 1);
        ticks(10);
        ticks(8);
        check("turn_mc1", int'(mc1_o), 32'h16);
        check("turn_mc2", int'(mc2_o), 32'h06);

        // Turn slice expiry: not clear stays, clear exits, exactly CLEAR exits
        pulse_dv(25, 25);
        ticks(40);
        check("turn_stay", int'(state_o), TURN);
        pulse_dv(40, 40);
        ticks(40);
        check("turn_exit40", int'(state_o), CRUISE);
        pulse_dv(10, 35);
        ticks(5);
        pulse_dv(30, 30);
        ticks(65);
        check("turn_exit30", int'(state_o), CRUISE);

        // Watchdog fault and recovery, then a reading on the expiry cycle
        pulse_dv(200, 200);
        ticks(100);
        run(2);
        check("wd_fault", int'(state_o), FAULT);
        ticks(12);
        check("fault_mc1", int'(mc1_o), 32'h10);
        check("fault_mc2", int'(mc2_o), 32'h10);
        pulse_dv(200, 200);
        check("fault_to_brake", int'(state_o), BRAKE);
        ticks(45);
        pulse_dv(200, 200);
        ticks(100);
        pulse_dv(200, 200);
        run(3);
        check("wd_race", int'(state_o), CRUISE);

        // Manual override mid-turn, then reset mid-ramp
        pulse_dv(5, 100);
        ticks(20);
        check("turn_again", int'(state_o), TURN);
        auto_en_i = 1'b0; man_mc1_i = 5'h1F; man_mc2_i = 5'h03;
        step(1'b0);
        check("override", int'(state_o), MANUAL);
        ticks(20);
        check("ovr_mc1", int'(mc1_o), 32'h1F);
        check("ovr_mc2", int'(mc2_o), 32'h03);
        man_mc1_i = 5'h05;
        ticks(3);
        check("midramp", int'(mc1_o), 32'h1C);
        reset_n_i = 1'b0;
        step(1'b1);
        check("rst_mc1", int'(mc1_o), 32'h10);
        reset_n_i = 1'b1;

        // Random traffic
        auto_en_i = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) auto_en_i = ~auto_en_i;
            if ($urandom_range(0, 49) == 0) begin
                man_mc1_i = 5'($urandom);
                man_mc2_i = 5'($urandom);
            end
            dist_valid_i = ($urandom_range(0, 29) == 0);
            dist1_i = 8'($urandom_range(0, 60));
            dist2_i = 8'($urandom_range(0, 60));
            step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
        end
        dist_valid_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
